// File: rtl/tqvp_uart_pkg.sv
// Shared UART constants and types for the TQVP UART peripheral.
package tqvp_uart_pkg;

  localparam int UART_RX_FIFO_DEPTH_LOG2 = 3;
  localparam int UART_RX_FIFO_RTS_MARGIN = 2;
  localparam int UART_DATA_W             = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/tqvp_uart_rx_fifo_if.sv
// Byte handshake between the RX deserialiser / CPU read port and the RX FIFO.
// The master side supplies bytes and pop requests; the slave side is the FIFO.
interface tqvp_uart_rx_fifo_if
  import tqvp_uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output in_valid, in_data, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  in_valid, in_data, rd_en,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/tqvp_sync_fifo.sv
// Generic synchronous FIFO core: register-array storage, extended pointers,
// show-ahead head output, and current/next occupancy.
module tqvp_sync_fifo
  import tqvp_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   level_d,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                push_ok;
  logic                pop_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(1);
    end
  end

  assign level_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/tqvp_uart_rx_fifo.sv
// UART receive FIFO with fill-level IRQ, sticky overflow and RTS watermark.
// Define UART_RX_FIFO_TIMEOUT_EN to add the idle-timeout counter and irq_timeout.
module tqvp_uart_rx_fifo
  import tqvp_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2,
  parameter int DATA_W     = UART_DATA_W,
  parameter int RTS_MARGIN = UART_RX_FIFO_RTS_MARGIN
) (
  input  logic                clk,
  input  logic                rst,
  tqvp_uart_rx_fifo_if.slave  bus,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  input  logic [DEPTH_LOG2:0] threshold,
  output logic                irq_level,
  output logic                overflow,
  input  logic                overflow_clr,
  output logic                uart_rts
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  input  logic [15:0]         timeout_cycles,
  output logic                irq_timeout
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] RTS_LIMIT = (DEPTH_LOG2+1)'(DEPTH - RTS_MARGIN - 1);

  logic                empty;
  logic [DEPTH_LOG2:0] level_d;
  logic                overflow_q, overflow_d;
  logic                rts_q, rts_d;

  tqvp_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .push_data (bus.in_data),
    .pop       (bus.rd_en),
    .head_data (bus.rd_data),
    .level     (level),
    .level_d   (level_d),
    .full      (full),
    .empty     (empty)
  );

  assign bus.rd_valid = !empty;

  // A drop in the same cycle as a clear must leave the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (bus.in_valid && full) overflow_d = 1'b1;
    rts_d = (level_d <= RTS_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      rts_q      <= 1'b1;
    end else begin
      overflow_q <= overflow_d;
      rts_q      <= rts_d;
    end
  end

  assign overflow  = overflow_q;
  assign uart_rts  = rts_q;
  assign irq_level = (threshold != '0) && (level >= threshold);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic        tmo_hit;
  logic        push_fire;
  logic        pop_fire;

  assign push_fire = bus.in_valid && !full;
  assign pop_fire  = bus.rd_en && !empty;
  assign tmo_hit   = (tmo_cnt_q == timeout_cycles) && (timeout_cycles != 16'd0) && !empty;

  // Counter measures idle time with data waiting; the flag latches the first hit.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    if (push_fire || pop_fire || empty) begin
      tmo_cnt_d = 16'd0;
    end else if (tmo_cnt_q != 16'hFFFF) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
    if (push_fire || pop_fire) begin
      tmo_flag_d = 1'b0;
    end else if (tmo_hit) begin
      tmo_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q  <= 16'd0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign irq_timeout = tmo_flag_q || tmo_hit;
`endif

endmodule
